// File: rtl/rd_control.sv
// rd_control: read-side sequencer issuing a diagonally skewed burst of per-lane
// read enables and address offsets for the systolic array's column memories.
`default_nettype none

module rd_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic [ADDR_W-1:0]              num_rows,
  output logic [WIDTH_HEIGHT-1:0]        rd_en,
  output logic [ADDR_W*WIDTH_HEIGHT-1:0] rd_addr,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [WIDTH_HEIGHT-1:0]          en_q, en_d;
  logic [ADDR_W*WIDTH_HEIGHT-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]                n_q, n_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             feed;
  logic [WIDTH_HEIGHT-1:0]          en_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    // Lane 0 keeps being fed until N vectors are issued; higher lanes follow one cycle apart.
    feed     = (cnt_q < n_q);
    en_shift = {en_q[WIDTH_HEIGHT-2:0], feed};

    case (state_q)
      S_IDLE: begin
        if (active) begin
          if (num_rows != '0) begin
            n_d     = num_rows;
            cnt_d   = ADDR_W'(1);
            en_d    = WIDTH_HEIGHT'(1);
            addr_d  = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RUN: begin
        if (!active) begin
          en_d    = '0;
          addr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          en_d = en_shift;
          if (feed) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
          // Offset advances after each enabled cycle so address k pairs with the k-th enable.
          for (int i = 0; i < WIDTH_HEIGHT; i++) begin
            addr_d[ADDR_W*i +: ADDR_W] = addr_q[ADDR_W*i +: ADDR_W]
                                       + {{(ADDR_W-1){1'b0}}, en_q[i]};
          end
          if (en_shift == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!active) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_en   = en_q;
  assign rd_addr = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_control.sv
// tb_rd_control: randomized self-checking bench for rd_control against a
// closed-form model of the skewed burst (per-lane enable window and offset count).
`default_nettype none

module tb_rd_control;

  localparam int W  = 16;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic [AW-1:0]   num_rows;
  logic [W-1:0]    rd_en;
  logic [AW*W-1:0] rd_addr;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_bad = 0;

  rd_control #(.WIDTH_HEIGHT(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .active   (active),
    .num_rows (num_rows),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Lane i is enabled on edges i+1 .. i+n after the start edge (edge 1).
  function automatic logic [W-1:0] exp_en(input int k, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      v[i] = ((k - 1 - i) >= 0) && ((k - 1 - i) < n);
    end
    return v;
  endfunction

  // Lane offset at edge k = number of that lane's enables on earlier edges.
  function automatic logic [AW*W-1:0] exp_addr(input int k, input int n);
    logic [AW*W-1:0] v;
    int c;
    v = '0;
    for (int i = 0; i < W; i++) begin
      c = k - 1 - i;
      if (c < 0) c = 0;
      if (c > n) c = n;
      v[AW*i +: AW] = AW'(c);
    end
    return v;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    active   = 1'b0;
    num_rows = '0;
    #12;
    n_cmp++; if (rd_en !== '0)   begin n_bad++; $display("FAIL reset rd_en got %h exp 0", rd_en); end
    n_cmp++; if (rd_addr !== '0) begin n_bad++; $display("FAIL reset rd_addr got %h exp 0", rd_addr); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset done got %b exp 0", done); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rd_en !== '0) begin n_bad++; $display("FAIL reset_idle rd_en got %h exp 0", rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  // Full burst with active held high past completion; num_rows is scrambled mid-run.
  task automatic test_burst(input int n, input string tag);
    logic [W-1:0]    e_en;
    logic [AW*W-1:0] e_addr;
    logic            e_busy;
    logic            e_done;
    @(negedge clk);
    num_rows = AW'(n);
    active   = 1'b1;
    for (int k = 1; k <= n + W + 3; k++) begin
      @(posedge clk); #1;
      e_en   = exp_en(k, n);
      e_addr = exp_addr(k, n);
      e_busy = (k <= n + W - 1);
      e_done = (k == n + W);
      n_cmp++; if (rd_en !== e_en) begin
        n_bad++; $display("FAIL %s rd_en k=%0d got %h exp %h", tag, k, rd_en, e_en);
      end
      n_cmp++; if (rd_addr !== e_addr) begin
        n_bad++; $display("FAIL %s rd_addr k=%0d got %h exp %h", tag, k, rd_addr, e_addr);
      end
      n_cmp++; if (busy !== e_busy) begin
        n_bad++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, busy, e_busy);
      end
      n_cmp++; if (done !== e_done) begin
        n_bad++; $display("FAIL %s done k=%0d got %b exp %b", tag, k, done, e_done);
      end
      num_rows = AW'($urandom);
    end
    @(negedge clk);
    active = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rd_en !== '0) begin n_bad++; $display("FAIL %s exit rd_en got %h exp 0", tag, rd_en); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s exit done got %b exp 0", tag, done); end
  endtask

  task automatic test_n0();
    @(negedge clk);
    num_rows = '0;
    active   = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL n0 done got %b exp 1", done); end
    n_cmp++; if (rd_en !== '0)  begin n_bad++; $display("FAIL n0 rd_en got %h exp 0", rd_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL n0 busy got %b exp 0", busy); end
    num_rows = 8'd7;
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL n0_hold done k=%0d got %b exp 0", k, done); end
      n_cmp++; if (rd_en !== '0)  begin n_bad++; $display("FAIL n0_hold rd_en k=%0d got %h exp 0", k, rd_en); end
    end
    @(negedge clk);
    active = 1'b0;
    @(posedge clk); #1;
    test_burst(2, "n0_then_n2");
  endtask

  task automatic test_abort();
    @(negedge clk);
    num_rows = 8'd10;
    active   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (rd_en !== exp_en(k, 10)) begin
        n_bad++; $display("FAIL abort_pre rd_en k=%0d got %h exp %h", k, rd_en, exp_en(k, 10));
      end
      n_cmp++; if (rd_addr !== exp_addr(k, 10)) begin
        n_bad++; $display("FAIL abort_pre rd_addr k=%0d got %h exp %h", k, rd_addr, exp_addr(k, 10));
      end
    end
    active = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (rd_en !== '0)   begin n_bad++; $display("FAIL abort rd_en k=%0d got %h exp 0", k, rd_en); end
      n_cmp++; if (rd_addr !== '0) begin n_bad++; $display("FAIL abort rd_addr k=%0d got %h exp 0", k, rd_addr); end
      n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL abort busy k=%0d got %b exp 0", k, busy); end
      n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL abort done k=%0d got %b exp 0", k, done); end
    end
    test_burst(10, "abort_restart");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    num_rows = 8'd20;
    active   = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    n_cmp++; if (rd_en !== exp_en(7, 20)) begin
      n_bad++; $display("FAIL areset_pre rd_en got %h exp %h", rd_en, exp_en(7, 20));
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (rd_en !== '0)   begin n_bad++; $display("FAIL areset rd_en got %h exp 0", rd_en); end
    n_cmp++; if (rd_addr !== '0) begin n_bad++; $display("FAIL areset rd_addr got %h exp 0", rd_addr); end
    n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL areset busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL areset done got %b exp 0", done); end
    active = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rd_en !== '0) begin n_bad++; $display("FAIL areset_hold rd_en got %h exp 0", rd_en); end
    @(negedge clk);
    reset = 1'b0;
    test_burst(3, "areset_then_n3");
  endtask

  task automatic test_random();
    int n;
    repeat (5) begin
      n = $urandom_range(1, 60);
      test_burst(n, "random");
    end
  endtask

  initial begin
    test_reset();
    test_burst(4, "n4");
    test_burst(1, "n1");
    test_n0();
    test_abort();
    test_async_reset();
    test_burst(255, "n255");
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
